// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: op codes,
// FSM states and the iteration-counter width helper.
package mcycle_pkg;

  typedef enum logic [1:0] {
    MCYCLE_OP_MUL_S = 2'b00,
    MCYCLE_OP_MUL_U = 2'b01,
    MCYCLE_OP_DIV_S = 2'b10,
    MCYCLE_OP_DIV_U = 2'b11
  } mcycle_op_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    COMPUTING = 2'b01,
    DONE      = 2'b10
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mcycle_div_core.sv
// Restoring-division datapath: one quotient bit per enabled cycle.
// quotient/remainder show the values after the step taken this cycle.
module mcycle_div_core
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // The held remainder is always below the divisor, so only the shifted
  // partial remainder needs the extra bit.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    if (trial[WIDTH]) begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b1};
    end
    quotient  = quo_next;
    remainder = rem_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (load) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvsr_q <= divisor;
    end else if (en) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
    end
  end

endmodule

// File: rtl/mcycle_muldiv.sv
// Iterative multiply/divide unit for the Execute stage.
// Build option MCYCLE_FAST_MUL_EN: single-cycle multiply in the first COMPUTING cycle.
module mcycle_muldiv
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  mcycle_op_t       op;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] raw1;
  logic             neg_res;
  logic             neg_rem;
  logic             div0;
  logic             ovf;

  logic             in_signed;
  logic             in_sign1;
  logic             in_sign2;
  logic [WIDTH-1:0] in_abs1;
  logic [WIDTH-1:0] in_abs2;

  logic             is_div;
  logic             load;
  logic             div_en;
  logic             mul_finish;
  logic             finish;
  logic [2*WIDTH-1:0] mul_mag;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] fix_quo;
  logic [WIDTH-1:0] fix_rem;

  always_comb begin
    in_signed = (MCycleOp == MCYCLE_OP_MUL_S) || (MCycleOp == MCYCLE_OP_DIV_S);
    in_sign1  = in_signed && Operand1[WIDTH-1];
    in_sign2  = in_signed && Operand2[WIDTH-1];
    in_abs1   = in_sign1 ? -Operand1 : Operand1;
    in_abs2   = in_sign2 ? -Operand2 : Operand2;
  end

  always_comb begin
    Busy   = Start && (state != DONE) && !RESET;
    is_div = (op == MCYCLE_OP_DIV_S) || (op == MCYCLE_OP_DIV_U);
    load   = (state == IDLE) && Start && !RESET;
    div_en = (state == COMPUTING) && Start && is_div && !RESET;
  end

`ifdef MCYCLE_FAST_MUL_EN
  logic [WIDTH-1:0] abs2;

  always_comb begin
    mul_mag    = {{WIDTH{1'b0}}, abs1} * {{WIDTH{1'b0}}, abs2};
    mul_finish = 1'b1;
  end
`else
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     add_sum;

  // Low half starts as the multiplier and is consumed from bit 0 while the
  // product grows into the high half; each step shifts the pair right.
  always_comb begin
    add_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, abs1} : '0);
    mul_mag    = {add_sum, acc[WIDTH-1:1]};
    mul_finish = (count == LAST);
  end
`endif

  mcycle_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (CLK),
    .reset     (RESET),
    .load      (load),
    .en        (div_en),
    .dividend  (in_abs1),
    .divisor   (in_abs2),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    finish  = is_div ? (count == LAST) : mul_finish;
    mul_res = neg_res ? -mul_mag : mul_mag;
    fix_quo = neg_res ? -quo : quo;
    fix_rem = neg_rem ? -rem : rem;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      count   <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            op      <= mcycle_op_t'(MCycleOp);
            abs1    <= in_abs1;
            raw1    <= Operand1;
            neg_res <= in_sign1 ^ in_sign2;
            neg_rem <= in_sign1;
            div0    <= (Operand2 == '0);
            ovf     <= (MCycleOp == MCYCLE_OP_DIV_S) && (Operand1 == MOST_NEG)
                       && (Operand2 == '1);
`ifdef MCYCLE_FAST_MUL_EN
            abs2    <= in_abs2;
`else
            acc     <= {{WIDTH{1'b0}}, in_abs2};
`endif
            count   <= '0;
            state   <= COMPUTING;
          end
        end
        COMPUTING: begin
          if (!Start) begin
            state <= IDLE;
          end else begin
            count <= count + CNT_W'(1);
`ifndef MCYCLE_FAST_MUL_EN
            if (!is_div) acc <= mul_mag;
`endif
            if (finish) begin
              state <= DONE;
              if (!is_div) begin
                Result1 <= mul_res[WIDTH-1:0];
                Result2 <= mul_res[2*WIDTH-1:WIDTH];
              end else if (div0) begin
                Result1 <= '1;
                Result2 <= raw1;
              end else if (ovf) begin
                Result1 <= MOST_NEG;
                Result2 <= '0;
              end else begin
                Result1 <= fix_quo;
                Result2 <= fix_rem;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
